// File: rtl/lu_pkg.sv
// rtl/lu_pkg.sv - shared constants for the LU coefficient loader
// Purpose: default word format, watchdog length, coefficient slot indices
//          and loader state encoding shared by RTL and bench.
// Ports:   none (package).
package lu_pkg;

    localparam int LU_WIDTH       = 16;
    localparam int LU_FBITS       = 4;
    localparam int LU_TIMEOUT_CYC = 4096;

    // Coefficient slots in arrival order: 3x3 matrix row-major, then RHS.
    localparam int NUM_COEFF = 12;
    localparam int IDX_A00   = 0;
    localparam int IDX_A01   = 1;
    localparam int IDX_A02   = 2;
    localparam int IDX_A10   = 3;
    localparam int IDX_A11   = 4;
    localparam int IDX_A12   = 5;
    localparam int IDX_A20   = 6;
    localparam int IDX_A21   = 7;
    localparam int IDX_A22   = 8;
    localparam int IDX_C0    = 9;
    localparam int IDX_C1    = 10;
    localparam int IDX_C2    = 11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_LAUNCH = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

endpackage

// File: rtl/lu_coeff_loader.sv
// rtl/lu_coeff_loader.sv - collects 12 coefficient words and launches the LU solver
// Purpose: accept A00..A22, C0..C2 over a valid/ready stream, present them
//          packed on coeff_out, pulse solve_en once, then wait for solve_done
//          under a watchdog. Optional macro LU_LOAD_PIVOT_CHECK_EN rejects a
//          load whose A00 is zero (ERROR + err_pivot instead of launching).
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   clear             synchronous abort to IDLE, clears error flags
//   in_valid/in_data  coefficient stream input
//   in_ready          loader accepts a word this cycle (IDLE/LOAD)
//   coeff_out         packed coefficients, word k at [WIDTH*k +: WIDTH]
//   solve_en          one-cycle solver start pulse
//   solve_done        solver completion, sampled in WAIT only
//   busy              state is not IDLE
//   err_timeout       sticky watchdog expiry flag
//   err_pivot         sticky zero-pivot flag (0 unless pivot check built in)
module lu_coeff_loader
    import lu_pkg::*;
#(
    parameter int WIDTH       = LU_WIDTH,
    parameter int FBITS       = LU_FBITS,
    parameter int TIMEOUT_CYC = LU_TIMEOUT_CYC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic [NUM_COEFF*WIDTH-1:0] coeff_out,
    output logic                       solve_en,
    input  logic                       solve_done,
    output logic                       busy,
    output logic                       err_timeout,
    output logic                       err_pivot
);

    localparam int CNT_W = $clog2(NUM_COEFF);
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_COEFF - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    // FBITS only describes the Q-format seen by the solver; it is checked
    // here so a nonsensical format is caught at elaboration.
    if (FBITS < 0 || FBITS >= WIDTH || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("lu_coeff_loader: need 0 <= FBITS < WIDTH and TIMEOUT_CYC >= 2");
    end

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [TO_W-1:0]  r_to;
    logic             r_err_to;
    logic [WIDTH-1:0] r_coeff [NUM_COEFF];

    logic             w_in_ready;
    logic             w_xfer;
    logic [CNT_W-1:0] w_wr_idx;
    logic             w_load_last;
    logic             w_pivot_zero;

    assign w_in_ready  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    // clear wins over a coincident transfer: the word is dropped.
    assign w_xfer      = in_valid && w_in_ready && !clear;
    assign w_wr_idx    = (r_state == ST_LOAD) ? r_cnt : '0;
    assign w_load_last = (r_state == ST_LOAD) && w_xfer && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_to     <= '0;
            r_err_to <= 1'b0;
        end else if (clear) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_to     <= '0;
            r_err_to <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_load_last) begin
                        r_cnt   <= '0;
                        r_state <= w_pivot_zero ? ST_ERROR : ST_LAUNCH;
                    end else if (w_xfer) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_LAUNCH: begin
                    r_to    <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // solve_done is checked first so it beats a coincident expiry.
                    if (solve_done) begin
                        r_state <= ST_IDLE;
                    end else if (r_to == TO_LAST) begin
                        r_state  <= ST_ERROR;
                        r_err_to <= 1'b1;
                    end else begin
                        r_to <= r_to + TO_W'(1);
                    end
                end
                ST_ERROR: begin
                    r_state <= ST_ERROR;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Words are only written on a transfer, and transfers are impossible
    // from LAUNCH onwards, so the solver's operands stay frozen until the
    // next load begins. clear deliberately leaves stored words alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_COEFF; k++) begin
                r_coeff[k] <= '0;
            end
        end else if (w_xfer) begin
            r_coeff[w_wr_idx] <= in_data;
        end
    end

`ifdef LU_LOAD_PIVOT_CHECK_EN
    logic r_err_piv;

    // A00 was stored on the first transfer, so it is valid at load completion.
    assign w_pivot_zero = (r_coeff[IDX_A00] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_piv <= 1'b0;
        end else if (clear) begin
            r_err_piv <= 1'b0;
        end else if (w_load_last && w_pivot_zero) begin
            r_err_piv <= 1'b1;
        end
    end

    assign err_pivot = r_err_piv;
`else
    assign w_pivot_zero = 1'b0;
    assign err_pivot    = 1'b0;
`endif

    for (genvar g = 0; g < NUM_COEFF; g++) begin : g_pack
        assign coeff_out[WIDTH*g +: WIDTH] = r_coeff[g];
    end

    assign in_ready    = w_in_ready;
    assign solve_en    = (r_state == ST_LAUNCH);
    assign busy        = (r_state != ST_IDLE);
    assign err_timeout = r_err_to;

endmodule

// File: tb/tb_lu_coeff_loader.sv
// tb/tb_lu_coeff_loader.sv - self-checking bench for lu_coeff_loader
// Purpose: table-driven load sequence plus hand-written corner sequences;
//          coefficient words are scoreboarded and compared at each solve_en.
//          Honors LU_LOAD_PIVOT_CHECK_EN for the zero-pivot expectations.
// Ports:   none (top-level bench).
module tb_lu_coeff_loader;
    import lu_pkg::*;

    localparam int W = LU_WIDTH;
    localparam int N = NUM_COEFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         solve_done;

    logic         a_in_ready, a_solve_en, a_busy, a_err_to, a_err_piv;
    logic [N*W-1:0] a_coeff;
    logic         b_in_ready, b_solve_en, b_busy, b_err_to, b_err_piv;
    logic [N*W-1:0] b_coeff;

    lu_coeff_loader u_dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (a_in_ready),
        .coeff_out   (a_coeff),
        .solve_en    (a_solve_en),
        .solve_done  (solve_done),
        .busy        (a_busy),
        .err_timeout (a_err_to),
        .err_pivot   (a_err_piv)
    );

    lu_coeff_loader #(.TIMEOUT_CYC(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (b_in_ready),
        .coeff_out   (b_coeff),
        .solve_en    (b_solve_en),
        .solve_done  (solve_done),
        .busy        (b_busy),
        .err_timeout (b_err_to),
        .err_pivot   (b_err_piv)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int a_pulses = 0;
    logic [W-1:0] sb_q[$];

    always @(posedge clk) begin
        if (a_solve_en) a_pulses++;
    end

    typedef struct {
        logic         valid;
        logic [W-1:0] data;
        logic         e_ready;
        logic         e_busy;
        logic         e_solve;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input logic [W-1:0] base, input int n, input bit push);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = base + W'(k);
            if (push) sb_q.push_back(base + W'(k));
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic sb_check(input string tag);
        logic [W-1:0] e;
        for (int k = 0; k < N; k++) begin
            if (sb_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("%s_w%0d", tag, k), 64'(a_coeff[k*W +: W]), 64'(e));
            end
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0;
        int n;

        for (int k = 0; k < 12; k++) begin
            tv[k].valid   = 1'b1;
            tv[k].data    = W'(16'h0010 * (k + 1));
            tv[k].e_ready = (k < 11);
            tv[k].e_busy  = 1'b1;
            tv[k].e_solve = (k == 11);
        end
        tv[12].valid   = 1'b0;
        tv[12].data    = '0;
        tv[12].e_ready = 1'b0;
        tv[12].e_busy  = 1'b1;
        tv[12].e_solve = 1'b0;

        // Reset state, sampled while rst is still high.
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; solve_done = 1'b0;
        #1;
        chk("rst_coeff", 64'(a_coeff == '0), 64'd1);
        chk("rst_ready", 64'(a_in_ready), 64'd1);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_solve", 64'(a_solve_en), 64'd0);
        chk("rst_errto", 64'(a_err_to), 64'd0);
        chk("rst_errpiv", 64'(a_err_piv), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Back-to-back load of 0x0010..0x00C0, launch one cycle after last word.
        p0 = a_pulses;
        for (int i = 0; i < 13; i++) begin
            in_valid = tv[i].valid;
            in_data  = tv[i].data;
            if (tv[i].valid) sb_q.push_back(tv[i].data);
            tick();
            chk($sformatf("tv%0d_ready", i), 64'(a_in_ready), 64'(tv[i].e_ready));
            chk($sformatf("tv%0d_busy", i), 64'(a_busy), 64'(tv[i].e_busy));
            chk($sformatf("tv%0d_solve", i), 64'(a_solve_en), 64'(tv[i].e_solve));
            if (a_solve_en) sb_check("load1");
        end
        in_valid = 1'b0;
        chk("load1_pulses", 64'(a_pulses - p0), 64'd1);

        // solve_done on the 20th WAIT cycle.
        repeat (19) tick();
        chk("wait_busy", 64'(a_busy), 64'd1);
        solve_done = 1'b1;
        tick();
        solve_done = 1'b0;
        chk("done_ready", 64'(a_in_ready), 64'd1);
        chk("done_busy", 64'(a_busy), 64'd0);
        chk("done_errto", 64'(a_err_to), 64'd0);
        chk("done_errpiv", 64'(a_err_piv), 64'd0);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("done_hold_w%0d", k), 64'(a_coeff[k*W +: W]), 64'(16'h0010 * (k + 1)));
        end
        chk("done_pulses", 64'(a_pulses - p0), 64'd1);
        do_clear();

        // Watchdog on the TIMEOUT_CYC=8 instance.
        load_words(16'h0A00, 12, 1'b1);
        chk("to_solve", 64'(b_solve_en), 64'd1);
        sb_check("load2");
        tick();
        n = 0;
        while (!b_err_to && n < 100) begin
            tick();
            n++;
        end
        chk("to_wait_cycles", 64'(n), 64'd8);
        chk("to_ready", 64'(b_in_ready), 64'd0);
        chk("to_busy", 64'(b_busy), 64'd1);
        repeat (3) tick();
        chk("to_sticky", 64'(b_err_to), 64'd1);
        chk("to_nosolve", 64'(b_solve_en), 64'd0);
        do_clear();
        chk("to_clr_err", 64'(b_err_to), 64'd0);
        chk("to_clr_ready", 64'(b_in_ready), 64'd1);
        chk("to_clr_busy", 64'(b_busy), 64'd0);

        // Five words then clear coincident with a sixth: sixth dropped.
        load_words(16'h0100, 5, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("abort_busy", 64'(a_busy), 64'd0);
        chk("abort_ready", 64'(a_in_ready), 64'd1);
        chk("abort_w0", 64'(a_coeff[0*W +: W]), 64'h0100);
        chk("abort_w4", 64'(a_coeff[4*W +: W]), 64'h0104);
        chk("abort_w5", 64'(a_coeff[5*W +: W]), 64'h0A05);
        load_words(16'h0201, 12, 1'b1);
        chk("reload_solve", 64'(a_solve_en), 64'd1);
        sb_check("reload");
        solve_done = 1'b1;
        tick();
        solve_done = 1'b0;
        do_clear();

        // Zero pivot: A00 = 0x0000.
        p0 = a_pulses;
        load_words(16'h0000, 12, 1'b1);
`ifdef LU_LOAD_PIVOT_CHECK_EN
        chk("piv_solve", 64'(a_solve_en), 64'd0);
        chk("piv_err", 64'(a_err_piv), 64'd1);
        chk("piv_ready", 64'(a_in_ready), 64'd0);
        tick();
        chk("piv_pulses", 64'(a_pulses - p0), 64'd0);
        chk("piv_sticky", 64'(a_err_piv), 64'd1);
        sb_q.delete();
        do_clear();
        chk("piv_clr", 64'(a_err_piv), 64'd0);
`else
        chk("piv_solve", 64'(a_solve_en), 64'd1);
        chk("piv_err", 64'(a_err_piv), 64'd0);
        sb_check("piv");
        tick();
        chk("piv_pulses", 64'(a_pulses - p0), 64'd1);
        do_clear();
`endif

        // Asynchronous reset mid-LOAD (cnt=7).
        load_words(16'h0300, 7, 1'b0);
        chk("midload_busy_pre", 64'(a_busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midload_coeff", 64'(a_coeff == '0), 64'd1);
        chk("midload_ready", 64'(a_in_ready), 64'd1);
        chk("midload_busy", 64'(a_busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        p0 = a_pulses;
        repeat (5) tick();
        chk("midload_pulses", 64'(a_pulses - p0), 64'd0);

        // Asynchronous reset mid-WAIT.
        load_words(16'h0400, 12, 1'b0);
        repeat (4) tick();
        chk("midwait_busy_pre", 64'(a_busy), 64'd1);
        p0 = a_pulses;
        #2;
        rst = 1'b1;
        #1;
        chk("midwait_coeff", 64'(a_coeff == '0), 64'd1);
        chk("midwait_busy", 64'(a_busy), 64'd0);
        chk("midwait_solve", 64'(a_solve_en), 64'd0);
        chk("midwait_errto", 64'(a_err_to), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) tick();
        chk("midwait_pulses", 64'(a_pulses - p0), 64'd0);
        chk("midwait_ready", 64'(a_in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lu_coeff_loader.md
LU_COEFF_LOADER -- requirements
Module: lu_coeff_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, coefficient word width (Q-format, signed).
REQ-002 SHALL have parameter FBITS, default 4, fractional bits; pass-through only, no arithmetic on it.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096, WAIT-state cycles before timeout.
REQ-004 SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort to IDLE.
- in_valid  in  1  in_data holds a coefficient.
- in_data  in  WIDTH  coefficient word.
- in_ready  out  1  loader accepts a word this cycle.
- coeff_out  out  12*WIDTH  packed coefficients; word k at [WIDTH*k+WIDTH-1 : WIDTH*k].
- solve_en  out  1  one-cycle start pulse to the solver.
- solve_done  in  1  solver finished, sampled in WAIT only.
- busy  out  1  state is not IDLE.
- err_timeout  out  1  solver did not finish in time (sticky).
- err_pivot  out  1  A00 was zero (sticky).

Function
REQ-005 SHALL accept a transfer when in_valid and in_ready are both high on a rising clk edge.
REQ-006 SHALL store words in arrival order as k = 0..11: A00, A01, A02, A10, A11, A12, A20, A21, A22, C0, C1, C2.
REQ-007 SHALL implement states IDLE, LOAD, LAUNCH, WAIT, ERROR.
REQ-008 SHALL drive in_ready high only in IDLE and LOAD.
REQ-009 SHALL, in IDLE on a transfer, store word 0, set the counter to 1, and go to LOAD.
REQ-010 SHALL, in LOAD on a transfer, store word[cnt] and increment cnt; on the transfer with cnt==11, go to LAUNCH.
REQ-011 SHALL, in LAUNCH, drive solve_en high for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-012 SHALL, in WAIT, return to IDLE on solve_done; otherwise increment the timeout counter, and on reaching TIMEOUT_CYC-1 go to ERROR and set err_timeout.
REQ-013 SHALL let solve_done win if it coincides with timeout expiry, going to IDLE with no error.
REQ-014 SHALL hold coeff_out constant from LAUNCH entry until the next transfer, so the solver sees stable operands.
REQ-015 SHALL, on clear in any state, go to IDLE, zero cnt and the timeout counter, and clear err_timeout and err_pivot; coeff_out is retained.
REQ-016 SHALL give clear priority over a coincident transfer; the word is not stored.
REQ-017 SHALL ignore in_valid while in_ready is low, and ignore solve_done outside WAIT.
REQ-018 SHALL leave ERROR only on clear; in_ready and solve_en stay low while in ERROR.
REQ-019 SHALL take minimum latency from the final transfer to solve_en of 1 cycle: transfer edge, then the LAUNCH cycle.

Reset
REQ-020 SHALL, while rst is high, immediately force: state IDLE, cnt 0, timeout counter 0, coeff_out all zero, solve_en 0, err_timeout 0, err_pivot 0.
REQ-021 SHALL give in_ready=1 and busy=0 from reset state; a reset mid-LOAD or mid-WAIT discards all progress with no solve_en pulse.

Configuration
REQ-022 SHALL, when macro LU_LOAD_PIVOT_CHECK_EN is defined, go from LOAD completion to ERROR with err_pivot set (no solve_en) if stored A00 == 0; otherwise go to LAUNCH.
REQ-023 SHALL, without LU_LOAD_PIVOT_CHECK_EN, tie err_pivot to 0 and always proceed to LAUNCH.

Structure
REQ-024 SHALL take WIDTH/FBITS defaults, the state encoding, coefficient index constants (IDX_A00..IDX_C2, NUM_COEFF=12) and the default TIMEOUT_CYC from shared package lu_pkg.
REQ-025 SHALL be implemented flat; no sub-module.

Verification
REQ-026 SHALL cover: reset, then 12 back-to-back words 0x0010..0x00C0 -> coeff_out word k = 0x0010*(k+1); one solve_en pulse 1 cycle after the last transfer; busy=1.
REQ-027 SHALL cover: WAIT with solve_done after 20 cycles -> IDLE, in_ready=1, coeff_out unchanged, no error flags.
REQ-028 SHALL cover: TIMEOUT_CYC=8 with solve_done never asserted -> ERROR after 8 WAIT cycles, err_timeout=1, in_ready=0; clear -> IDLE, err_timeout=0.
REQ-029 SHALL cover: 5 words, then clear coincident with in_valid -> IDLE, cnt=0, 6th word not stored; reload of 12 words -> correct ordering.
REQ-030 SHALL cover: with LU_LOAD_PIVOT_CHECK_EN, A00=0x0000 -> err_pivot=1, no solve_en; without the macro, the same stimulus -> solve_en pulse, err_pivot=0.
REQ-031 SHALL cover: rst asserted mid-LOAD (cnt=7) and mid-WAIT -> asynchronous return to reset values, no solve_en pulse.
